// File: rtl/spram_pkg.sv
// Shared constants and helpers for the byte-enable single-port SRAM (spram_be).
package spram_pkg;

   // Read-during-write behaviour selectors
   localparam int unsigned RDW_NO_CHANGE   = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;
   localparam int unsigned RDW_READ_FIRST  = 2;

   // Fill sequencer states
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   // Widest lane the parity helper accepts; narrower lanes are zero-extended
   localparam int unsigned PAR_LANE_MAX = 64;

   // Even parity of one byte lane (zero-extension leaves the parity unchanged)
   function automatic logic lane_parity(input logic [PAR_LANE_MAX-1:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/spram_rd_pipe.sv
// Read response pipeline for spram_be: 1 or 2 register stages for data,
// valid and parity error. rdata holds its last value between responses.
module spram_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  err
);

   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_err;

   generate
      if (LATENCY == 2) begin : g_stage
         // Extra register between the array read and the output register
         always_ff @(posedge clk) begin
            if (rst) begin
               s_valid <= 1'b0;
               s_data  <= '0;
               s_err   <= 1'b0;
            end else begin
               s_valid <= in_valid;
               s_data  <= in_data;
               s_err   <= in_err & in_valid;
            end
         end
      end else begin : g_direct
         assign s_valid = in_valid;
         assign s_data  = in_data;
         assign s_err   = in_err;
      end
   endgenerate

   // Output register: valid/err pulse per response, data held when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
         err    <= 1'b0;
      end else begin
         rvalid <= s_valid;
         err    <= s_valid & s_err;
         if (s_valid) begin
            rdata <= s_data;
         end
      end
   end

endmodule

// File: rtl/spram_be.sv
// Single-port synchronous SRAM with byte-lane write enables, 1/2-cycle read
// latency, selectable read-during-write response and post-reset zero-fill.
// Optional per-lane even parity is enabled by defining SPRAM_BE_PARITY_EN.
module spram_be
   import spram_pkg::*;
#(
   parameter int unsigned RAM_SIZE       = 1024,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BYTE_WIDTH     = 8,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned RDW_MODE       = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             we,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
   input  logic [ADDR_WIDTH-1:0]            addr,
   input  logic [DATA_WIDTH-1:0]            wdata,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             rvalid,
   output logic                             ready,
   output logic                             parity_err
);

   localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

   generate
      if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
         $error("spram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
      if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
         $error("spram_be: READ_LATENCY must be 1 or 2");
      end
      if (RAM_SIZE > (2 ** ADDR_WIDTH)) begin : g_bad_size
         $error("spram_be: RAM_SIZE exceeds the address space");
      end
   endgenerate

   logic [0:0]            state;
   logic [0:0]            state_nxt;
   logic [IDX_W-1:0]      fill_cnt;
   logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

   logic [IDX_W-1:0]      idx_c;
   logic                  in_range_c;
   logic                  acc_c;
   logic                  wr_c;
   logic                  rd_c;
   logic                  fill_we_c;
   logic                  fill_last_c;
   logic [DATA_WIDTH-1:0] old_c;
   logic [DATA_WIDTH-1:0] merged_c;
   logic                  resp_valid_c;
   logic [DATA_WIDTH-1:0] resp_data_c;
   logic                  resp_err_c;

   // Access decode, byte-lane merge and read-during-write response select
   always_comb begin
      idx_c       = IDX_W'(addr);
      in_range_c  = ({1'b0, addr} < (ADDR_WIDTH + 1)'(RAM_SIZE));
      acc_c       = en & ready;
      wr_c        = acc_c & we;
      rd_c        = acc_c & ~we;
      fill_we_c   = (state == ST_CLEAR);
      fill_last_c = fill_we_c && (fill_cnt == IDX_W'(RAM_SIZE - 1));
      old_c       = in_range_c ? mem[idx_c] : '0;
      merged_c    = old_c;
      for (int unsigned i = 0; i < NB; i++) begin
         if (be[i]) begin
            merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      resp_valid_c = rd_c | (wr_c & (RDW_MODE != RDW_NO_CHANGE));
      resp_data_c  = (wr_c && (RDW_MODE == RDW_WRITE_FIRST) && in_range_c) ? merged_c : old_c;
   end

   // Fill sequencer next state: CLEAR walks the array once, RUN is terminal
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (fill_last_c) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   // Sequencer state, fill counter and ready (high one cycle after RUN entry)
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         fill_cnt <= '0;
         ready    <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= (state == ST_RUN);
         if (fill_we_c) begin
            fill_cnt <= fill_cnt + IDX_W'(1);
         end
      end
   end

   // Array write port: zero-fill has priority, out-of-range writes are dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_we_c) begin
            mem[fill_cnt] <= '0;
         end else if (wr_c && in_range_c) begin
            mem[idx_c] <= merged_c;
         end
      end
   end

`ifdef SPRAM_BE_PARITY_EN
   logic [NB-1:0] par_mem [RAM_SIZE];
   logic [NB-1:0] old_par_c;
   logic [NB-1:0] merged_par_c;
   logic [NB-1:0] resp_par_c;

   // Parity of written lanes, and check of the response word against stored parity
   always_comb begin
      old_par_c    = in_range_c ? par_mem[idx_c] : '0;
      merged_par_c = old_par_c;
      for (int unsigned i = 0; i < NB; i++) begin
         if (be[i]) begin
            merged_par_c[i] = lane_parity(PAR_LANE_MAX'(wdata[i*BYTE_WIDTH +: BYTE_WIDTH]));
         end
      end
      resp_par_c = (wr_c && (RDW_MODE == RDW_WRITE_FIRST) && in_range_c) ? merged_par_c : old_par_c;
      resp_err_c = 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
         resp_err_c = resp_err_c |
                      (resp_par_c[i] ^ lane_parity(PAR_LANE_MAX'(resp_data_c[i*BYTE_WIDTH +: BYTE_WIDTH])));
      end
   end

   // Parity array write port, tracking the data array
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_we_c) begin
            par_mem[fill_cnt] <= '0;
         end else if (wr_c && in_range_c) begin
            par_mem[idx_c] <= merged_par_c;
         end
      end
   end
`else
   assign resp_err_c = 1'b0;
`endif

   spram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (READ_LATENCY)
   ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_valid (resp_valid_c),
      .in_data  (resp_data_c),
      .in_err   (resp_err_c),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .err      (parity_err)
   );

endmodule
